// File: rtl/demux4_buf_pkg.sv
// Shared constants and types for the demux4_buf slice.
// Optional per-channel delivery counters are enabled with DEMUX4_CNT_EN.
package demux4_buf_pkg;

    localparam int unsigned num_ch = 4;  // output channel count
    localparam int unsigned sel_w  = 2;  // destination select width
    localparam int unsigned cnt_w  = 8;  // per-channel delivery counter width

    typedef logic [sel_w-1:0] ch_idx_t;

    // One-entry slot occupancy
    typedef enum logic {SlotEmpty, SlotFull} slot_state_t;

endpackage

// File: rtl/demux4_slot.sv
// One-entry valid/ready holding register for one demux output channel.
// With DEMUX4_CNT_EN defined, also counts deliveries on an 8-bit wrapping counter.
module demux4_slot
    import demux4_buf_pkg::*;
#(
    parameter int unsigned size = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,       // accept targets this slot this cycle
    input  logic [size-1:0] load_data,
    input  logic            ready,      // consumer takes the word this cycle
    output logic            valid,
    output logic [size-1:0] data
`ifdef DEMUX4_CNT_EN
    ,
    output logic [cnt_w-1:0] cnt
`endif
);

    slot_state_t     state_q;
    logic [size-1:0] data_q;
    logic            deliver;

    assign deliver = (state_q == SlotFull) && ready;
    assign valid   = (state_q == SlotFull);
    assign data    = data_q;

    // Slot state and contents; a load on the delivery edge keeps the slot full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SlotEmpty;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                SlotEmpty: if (load) state_q <= SlotFull;
                SlotFull:  if (ready && !load) state_q <= SlotEmpty;
                default:   state_q <= SlotEmpty;
            endcase
            if (load) data_q <= load_data;
        end
    end

`ifdef DEMUX4_CNT_EN
    logic [cnt_w-1:0] cnt_q;

    assign cnt = cnt_q;

    // Delivery counter, wraps naturally at 2**cnt_w
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (deliver) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready slot per channel.
// Define DEMUX4_CNT_EN to add the xfer_cnt port (8-bit delivery count per channel).
module demux4_buf
    import demux4_buf_pkg::*;
#(
    parameter int unsigned size = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [size-1:0]   in_data,
    input  ch_idx_t           in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [size-1:0]   out0_data,
    output logic [size-1:0]   out1_data,
    output logic [size-1:0]   out2_data,
    output logic [size-1:0]   out3_data,
    output logic [num_ch-1:0] out_valid,
    input  logic [num_ch-1:0] out_ready
`ifdef DEMUX4_CNT_EN
    ,
    output logic [num_ch*cnt_w-1:0] xfer_cnt
`endif
);

    logic [num_ch-1:0] load;
    logic [size-1:0]   slot_data [num_ch];

    // Only the targeted channel can stall the input, independent of in_valid
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    // Decode the accepted word to a one-hot slot load
    always_comb begin
        load = '0;
        if (in_valid && in_ready) load[in_sel] = 1'b1;
    end

    for (genvar k = 0; k < num_ch; k++) begin : g_slot
        demux4_slot #(
            .size (size)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (slot_data[k])
`ifdef DEMUX4_CNT_EN
            ,
            .cnt       (xfer_cnt[cnt_w*k +: cnt_w])
`endif
        );
    end

    assign out0_data = slot_data[0];
    assign out1_data = slot_data[1];
    assign out2_data = slot_data[2];
    assign out3_data = slot_data[3];

endmodule
